// File: rtl/icache_fetch_arbiter.sv
// icache_fetch_arbiter: shares one multi-burst instruction-cache port between
// the two fetch paths. Round-robin grant, one-cycle cache request pulse,
// bursts routed to the owning path only, release on burst_done.
//
// Optional feature: define ICACHE_ARB_TIMEOUT_EN to add a WAIT-state watchdog
// that ends a transaction with rsp_err after TIMEOUT_CYCLES of cache silence.
//
// Handshake: a requester holds req_valid (with its addr/count stable) until it
// sees req_ready pulse for one cycle; that cycle is the accept and the request
// inputs are sampled in it. Dropping req_valid before the pulse withdraws the
// request silently. rsp_valid/rsp_done are one-cycle pulses with no back-pressure.
module icache_fetch_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 128,
  parameter int CNT_W          = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [CNT_W-1:0]  req_count0,
  input  logic [CNT_W-1:0]  req_count1,
  output logic [1:0]        req_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_valid,
  output logic [1:0]        rsp_done,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] cache_addr_out,
  output logic              cache_request_out,
  output logic [CNT_W-1:0]  cache_ins_count_out,
  input  logic [DATA_W-1:0] cache_rdata_in,
  input  logic              cache_rvalid_in,
  input  logic              cache_burst_done_in
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // A burst carries at most four instructions; a count of zero also means four.
  localparam logic [CNT_W:0] BURST_WORDS = (CNT_W + 1)'(4);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W:0]    exp_words_q, exp_words_d;
  logic [CNT_W:0]    got_words_q, got_words_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_done_q, rsp_done_d;
  logic              rsp_err_q, rsp_err_d;

  logic              sel;
  logic [CNT_W:0]    remaining;
  logic [CNT_W:0]    inc;
  logic [CNT_W:0]    got_next;

`ifdef ICACHE_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  // Keeps the parameter referenced when the watchdog is compiled out.
  logic unused_tmo_param;
  assign unused_tmo_param = (TIMEOUT_CYCLES > 0);
`endif

  // Next-state, grant and response logic for the IDLE/ISSUE/WAIT sequence.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    addr_d      = addr_q;
    count_d     = count_q;
    exp_words_d = exp_words_q;
    got_words_d = got_words_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 2'b00;
    rsp_done_d  = 2'b00;
    rsp_err_d   = 1'b0;
    req_ready   = 2'b00;
    remaining   = '0;
    inc         = '0;
    got_next    = got_words_q;
`ifdef ICACHE_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    sel = (req_valid == 2'b11) ? rr_q : req_valid[1];

    case (state_q)
      S_IDLE: begin
        // The cycle that shows rsp_done never accepts a new request.
        if (!reset && (req_valid != 2'b00) && (rsp_done_q == 2'b00)) begin
          req_ready[sel] = 1'b1;
          owner_d        = sel;
          addr_d         = sel ? req_addr1 : req_addr0;
          count_d        = sel ? req_count1 : req_count0;
          exp_words_d    = (count_d == '0) ? BURST_WORDS : {1'b0, count_d};
          got_words_d    = '0;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ICACHE_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (cache_rvalid_in) begin
          remaining              = exp_words_q - got_words_q;
          inc                    = (remaining > BURST_WORDS) ? BURST_WORDS : remaining;
          got_next               = got_words_q + inc;
          got_words_d            = got_next;
          rsp_data_d             = cache_rdata_in;
          rsp_valid_d[owner_q]   = 1'b1;
`ifdef ICACHE_ARB_TIMEOUT_EN
          tmo_d                  = '0;
        end else begin
          tmo_d                  = tmo_q + 1'b1;
`endif
        end
        // A burst in the same cycle as burst_done is already counted in got_next.
        if (cache_burst_done_in) begin
          rsp_done_d[owner_q] = 1'b1;
          rsp_err_d           = (got_next != exp_words_q);
          rr_d                = ~owner_q;
          state_d             = S_IDLE;
        end
`ifdef ICACHE_ARB_TIMEOUT_EN
        else if (!cache_rvalid_in && (tmo_q == TMO_W'(TIMEOUT_CYCLES))) begin
          rsp_done_d[owner_q] = 1'b1;
          rsp_err_d           = 1'b1;
          rr_d                = ~owner_q;
          state_d             = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction without rsp_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      exp_words_q <= '0;
      got_words_q <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 2'b00;
      rsp_done_q  <= 2'b00;
      rsp_err_q   <= 1'b0;
`ifdef ICACHE_ARB_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      exp_words_q <= exp_words_d;
      got_words_q <= got_words_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_done_q  <= rsp_done_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ICACHE_ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign rsp_data            = rsp_data_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_done            = rsp_done_q;
  assign rsp_err             = rsp_err_q;
  assign cache_addr_out      = addr_q;
  assign cache_ins_count_out = count_q;
  assign cache_request_out   = (state_q == S_ISSUE) && !reset;

endmodule

// File: tb/tb_icache_fetch_arbiter.sv
// tb_icache_fetch_arbiter: directed and randomized transactions against a
// transaction-level model (owner choice, delivered-word arithmetic, burst data).
module tb_icache_fetch_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 3;
`ifdef ICACHE_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic              clk;
  logic              reset;
  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0, req_addr1;
  logic [CNT_W-1:0]  req_count0, req_count1;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_valid, rsp_done;
  logic              rsp_err;
  logic [ADDR_W-1:0] cache_addr_out;
  logic              cache_request_out;
  logic [CNT_W-1:0]  cache_ins_count_out;
  logic [DATA_W-1:0] cache_rdata_in;
  logic              cache_rvalid_in, cache_burst_done_in;

  icache_fetch_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_count0(req_count0), .req_count1(req_count1),
    .req_ready(req_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .rsp_done(rsp_done), .rsp_err(rsp_err),
    .cache_addr_out(cache_addr_out), .cache_request_out(cache_request_out),
    .cache_ins_count_out(cache_ins_count_out), .cache_rdata_in(cache_rdata_in),
    .cache_rvalid_in(cache_rvalid_in), .cache_burst_done_in(cache_burst_done_in)
  );

  // Clock and global time bound.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int                n_checks = 0;
  int                n_pass   = 0;
  logic [DATA_W-1:0] exp_q[$];
  bit                m_rr;
  int                saw_valid, saw_done;

  // Burst b of a transaction: lane j holds the PC of instruction 4b+j, zero past the count.
  function automatic logic [DATA_W-1:0] burst_data(input logic [31:0] a, input int b, input int words);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      if (4 * b + j < words) r[32*j +: 32] = a + 32'(4 * (4 * b + j));
    end
    return r;
  endfunction

  task automatic clear_cache();
    cache_rvalid_in     = 1'b0;
    cache_burst_done_in = 1'b0;
    cache_rdata_in      = '0;
  endtask

  // Per-cycle check while a transaction is in WAIT or just finishing.
  task automatic mon(input bit own, input bit err_exp);
    logic [DATA_W-1:0] e;
    n_checks++;
    if (req_ready !== 2'b00) $display("FAIL ready_busy got=%b exp=00", req_ready); else n_pass++;
    n_checks++;
    if (cache_request_out !== 1'b0) $display("FAIL req_pulse_extra got=%b exp=0", cache_request_out); else n_pass++;
    if (rsp_valid !== 2'b00) begin
      saw_valid++;
      n_checks++;
      if (rsp_valid !== (2'b01 << own)) $display("FAIL rsp_valid_owner got=%b exp=%b", rsp_valid, 2'b01 << own);
      else n_pass++;
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL rsp_valid_unexpected data=%h", rsp_data);
      else begin
        e = exp_q.pop_front();
        if (rsp_data !== e) $display("FAIL rsp_data got=%h exp=%h", rsp_data, e); else n_pass++;
      end
    end
    if (rsp_done !== 2'b00) begin
      saw_done++;
      n_checks++;
      if (rsp_done !== (2'b01 << own)) $display("FAIL rsp_done_owner got=%b exp=%b", rsp_done, 2'b01 << own);
      else n_pass++;
      n_checks++;
      if (rsp_err !== err_exp) $display("FAIL rsp_err got=%b exp=%b", rsp_err, err_exp); else n_pass++;
    end
  endtask

  // Full transaction: request, grant, issue, lat idle cycles, nb bursts, burst_done.
  task automatic run_txn(input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [2:0] c0, input logic [2:0] c1, input int lat, input int nb,
                         input bit merge, input bit junk, input bit hold);
    bit          own, err;
    logic [31:0] a;
    logic [2:0]  c;
    int          words, deliv, k;
    logic [DATA_W-1:0] d;
    own   = (vld == 2'b11) ? m_rr : vld[1];
    a     = own ? a1 : a0;
    c     = own ? c1 : c0;
    words = (c == 3'd0) ? 4 : int'(c);
    deliv = (4 * nb < words) ? 4 * nb : words;
    err   = (deliv != words);

    @(negedge clk);
    req_valid = vld; req_addr0 = a0; req_addr1 = a1; req_count0 = c0; req_count1 = c1;
    #1;
    k = 0;
    while (req_ready === 2'b00 && k < 8) begin
      @(negedge clk); #1; k++;
    end
    n_checks++;
    if (req_ready !== (2'b01 << own)) $display("FAIL grant got=%b exp=%b", req_ready, 2'b01 << own);
    else n_pass++;
    n_checks++;
    if (rsp_done !== 2'b00) $display("FAIL grant_with_done rsp_done=%b exp=00", rsp_done); else n_pass++;

    // ISSUE cycle; junk cache activity here must be ignored.
    @(negedge clk);
    if (!hold) req_valid = 2'b00;
    if (junk) begin
      cache_rvalid_in = 1'b1; cache_burst_done_in = 1'b1; cache_rdata_in = {4{$urandom}};
    end
    #1;
    n_checks++;
    if (cache_request_out !== 1'b1) $display("FAIL issue_pulse got=%b exp=1", cache_request_out); else n_pass++;
    n_checks++;
    if (cache_addr_out !== a) $display("FAIL issue_addr got=%h exp=%h", cache_addr_out, a); else n_pass++;
    n_checks++;
    if (cache_ins_count_out !== c) $display("FAIL issue_count got=%0d exp=%0d", cache_ins_count_out, c); else n_pass++;
    n_checks++;
    if (req_ready !== 2'b00) $display("FAIL issue_ready got=%b exp=00", req_ready); else n_pass++;

    saw_valid = 0; saw_done = 0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); clear_cache(); #1; mon(own, err);
    end
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      d = burst_data(a, b, words);
      cache_rvalid_in = 1'b1; cache_rdata_in = d;
      cache_burst_done_in = merge && (b == nb - 1);
      exp_q.push_back(d);
      #1; mon(own, err);
    end
    if (!(merge && nb > 0)) begin
      @(negedge clk); clear_cache(); cache_burst_done_in = 1'b1; #1; mon(own, err);
    end
    @(negedge clk); clear_cache(); #1; mon(own, err);
    n_checks++;
    if (saw_done != 1) $display("FAIL done_count got=%0d exp=1", saw_done); else n_pass++;
    n_checks++;
    if (saw_valid != nb) $display("FAIL burst_count got=%0d exp=%0d", saw_valid, nb); else n_pass++;
    n_checks++;
    if (cache_addr_out !== a) $display("FAIL addr_hold got=%h exp=%h", cache_addr_out, a); else n_pass++;
    exp_q.delete();
    m_rr = ~own;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11; req_addr0 = 32'h55; req_addr1 = 32'h66; req_count0 = 3'd1; req_count1 = 3'd2;
    cache_rvalid_in = 1'b1; cache_burst_done_in = 1'b1; cache_rdata_in = {4{32'hdeadbeef}};
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_ready got=%b exp=00", req_ready); else n_pass++;
    n_checks++; if (cache_request_out !== 1'b0) $display("FAIL reset_req got=%b exp=0", cache_request_out); else n_pass++;
    n_checks++; if (rsp_valid !== 2'b00) $display("FAIL reset_valid got=%b exp=00", rsp_valid); else n_pass++;
    n_checks++; if (rsp_done !== 2'b00) $display("FAIL reset_done got=%b exp=00", rsp_done); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", rsp_err); else n_pass++;
    n_checks++; if (rsp_data !== '0) $display("FAIL reset_data got=%h exp=0", rsp_data); else n_pass++;
    n_checks++; if (cache_addr_out !== '0) $display("FAIL reset_addr got=%h exp=0", cache_addr_out); else n_pass++;
    n_checks++; if (cache_ins_count_out !== '0) $display("FAIL reset_count got=%0d exp=0", cache_ins_count_out); else n_pass++;
    @(negedge clk);
    reset = 1'b0; req_valid = 2'b00; clear_cache();
    m_rr = 1'b0;
  endtask

  task automatic test_single();
    run_txn(2'b01, 32'h10, 32'h0, 3'd4, 3'd0, 1, 1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rsp_data !== 128'h0000001C_00000018_00000014_00000010)
      $display("FAIL single_data got=%h exp=0000001c000000180000001400000010", rsp_data);
    else n_pass++;
  endtask

  task automatic test_multi_burst();
    run_txn(2'b01, 32'h0, 32'h0, 3'd7, 3'd0, 0, 2, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rsp_data !== {32'h0, 32'h18, 32'h14, 32'h10})
      $display("FAIL multi_data got=%h exp=00000000000000180000001400000010", rsp_data);
    else n_pass++;
  endtask

  task automatic test_contention();
    run_txn(2'b11, 32'h200, 32'h300, 3'd3, 3'd5, 1, 1, 1'b0, 1'b0, 1'b1);
    run_txn(2'b11, 32'h200, 32'h300, 3'd3, 3'd5, 0, 2, 1'b1, 1'b0, 1'b1);
    run_txn(2'b11, 32'h200, 32'h300, 3'd3, 3'd5, 2, 1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_count_zero();
    run_txn(2'b10, 32'h0, 32'h40, 3'd0, 3'd0, 2, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    int k;
    // Leave priority pointing at requester 1 so the reset's effect on it is visible.
    run_txn(2'b01, 32'h80, 32'h0, 3'd2, 3'd0, 0, 1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 2'b01; req_addr0 = 32'h100; req_count0 = 3'd2; #1;
    k = 0;
    while (req_ready === 2'b00 && k < 8) begin @(negedge clk); #1; k++; end
    n_checks++; if (req_ready !== 2'b01) $display("FAIL abort_grant got=%b exp=01", req_ready); else n_pass++;
    @(negedge clk); req_valid = 2'b00; #1;
    n_checks++; if (cache_request_out !== 1'b1) $display("FAIL abort_issue got=%b exp=1", cache_request_out); else n_pass++;
    @(negedge clk); clear_cache();
    @(negedge clk);
    reset = 1'b1; cache_rvalid_in = 1'b1; cache_burst_done_in = 1'b1; cache_rdata_in = {4{$urandom}};
    @(negedge clk);
    reset = 1'b0; clear_cache(); #1;
    n_checks++; if (rsp_valid !== 2'b00) $display("FAIL abort_valid got=%b exp=00", rsp_valid); else n_pass++;
    n_checks++; if (rsp_done !== 2'b00) $display("FAIL abort_done got=%b exp=00", rsp_done); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL abort_err got=%b exp=0", rsp_err); else n_pass++;
    n_checks++; if (rsp_data !== '0) $display("FAIL abort_data got=%h exp=0", rsp_data); else n_pass++;
    n_checks++; if (cache_addr_out !== '0) $display("FAIL abort_addr got=%h exp=0", cache_addr_out); else n_pass++;
    n_checks++; if (cache_request_out !== 1'b0) $display("FAIL abort_req got=%b exp=0", cache_request_out); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++; if (rsp_done !== 2'b00) $display("FAIL abort_late_done got=%b exp=00", rsp_done); else n_pass++;
    end
    m_rr = 1'b0;
    run_txn(2'b11, 32'h500, 32'h600, 3'd6, 3'd1, 1, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] vld;
    logic [2:0] c0, c1;
    int         need, nb, words;
    bit         own;
    for (int t = 0; t < 24; t++) begin
      vld   = 2'($urandom_range(1, 3));
      c0    = 3'($urandom_range(0, 7));
      c1    = 3'($urandom_range(0, 7));
      own   = (vld == 2'b11) ? m_rr : vld[1];
      words = ((own ? c1 : c0) == 3'd0) ? 4 : int'(own ? c1 : c0);
      need  = (words + 3) / 4;
      nb    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : need;
      run_txn(vld, $urandom & 32'hffff_fffc, $urandom & 32'hffff_fffc, c0, c1,
              int'($urandom_range(0, 3)), nb, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

`ifdef ICACHE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int  k;
    bit  own;
    own = 1'b1;
    @(negedge clk);
    req_valid = 2'b10; req_addr1 = 32'h700; req_count1 = 3'd5; #1;
    k = 0;
    while (req_ready === 2'b00 && k < 8) begin @(negedge clk); #1; k++; end
    n_checks++; if (req_ready !== 2'b10) $display("FAIL tmo_grant got=%b exp=10", req_ready); else n_pass++;
    @(negedge clk); req_valid = 2'b00; #1;
    n_checks++; if (cache_request_out !== 1'b1) $display("FAIL tmo_issue got=%b exp=1", cache_request_out); else n_pass++;
    // WAIT is entered on the next cycle; done is due TMO+1 cycles after that.
    k = 0;
    while (k < 3 * TMO) begin
      @(negedge clk); #1; k++;
      if (rsp_done !== 2'b00) break;
    end
    n_checks++; if (k != TMO + 2) $display("FAIL tmo_latency got=%0d exp=%0d", k, TMO + 2); else n_pass++;
    n_checks++; if (rsp_done !== 2'b10) $display("FAIL tmo_done got=%b exp=10", rsp_done); else n_pass++;
    n_checks++; if (rsp_err !== 1'b1) $display("FAIL tmo_err got=%b exp=1", rsp_err); else n_pass++;
    @(negedge clk); cache_rvalid_in = 1'b1; cache_burst_done_in = 1'b1; cache_rdata_in = {4{$urandom}};
    @(negedge clk); clear_cache(); #1;
    n_checks++; if (rsp_valid !== 2'b00) $display("FAIL tmo_late_valid got=%b exp=00", rsp_valid); else n_pass++;
    n_checks++; if (rsp_done !== 2'b00) $display("FAIL tmo_late_done got=%b exp=00", rsp_done); else n_pass++;
    m_rr = ~own;
  endtask
`endif

  initial begin
    reset = 1'b1; req_valid = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_count0 = '0; req_count1 = '0;
    clear_cache();
    m_rr = 1'b0;
    test_reset();
    test_single();
    test_multi_burst();
    test_contention();
    test_count_zero();
    test_reset_mid_wait();
`ifdef ICACHE_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
